// File: rtl/global_if.sv
// Global control bundle shared by the LED controller blocks.
// Carries the async reset and the low-power freeze request.
interface global_if;
  logic reset;
  logic sleep;

  modport src (
    output reset,
    output sleep
  );

  modport sink (
    input reset,
    input sleep
  );
endinterface

// File: rtl/multichannel_clock_divider.sv
// N-channel programmable clock divider with per-channel duty,
// boundary-only reconfiguration, phase sync and sleep freeze.
module multichannel_clock_divider #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                               clk_in,
  global_if.sink                             glb,
  input  logic [CHANNELS-1:0]                enable,
  input  logic [CHANNELS-1:0][WIDTH-1:0]     divisor,
  input  logic [CHANNELS-1:0][WIDTH-1:0]     duty,
  input  logic                               sync_strobe,
  output logic [CHANNELS-1:0]                clk_out,
  output logic [CHANNELS-1:0]                period_done
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);

  logic rst;
  logic sleep;

  assign rst   = glb.reset;
  assign sleep = glb.sleep;

  logic [CHANNELS-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0] pa_q, pa_d;
  logic [CHANNELS-1:0][WIDTH-1:0] ha_q, ha_d;
  logic [CHANNELS-1:0]            act_q, act_d;
  logic [CHANNELS-1:0]            clk_q, clk_d;
  logic [CHANNELS-1:0]            pd_q, pd_d;

  function automatic logic [WIDTH-1:0] heff(
    input logic [WIDTH-1:0] p,
    input logic [WIDTH-1:0] h
  );
    return (h < p) ? h : p;
  endfunction

  // act_q marks a channel that has loaded a runnable period;
  // a channel that is not active reloads before its first cnt=0.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_d[c] = cnt_q[c];
      pa_d[c]  = pa_q[c];
      ha_d[c]  = ha_q[c];
      act_d[c] = act_q[c];
      clk_d[c] = 1'b0;
      pd_d[c]  = 1'b0;

      if (!enable[c]) begin
        cnt_d[c] = ZERO;
        pa_d[c]  = divisor[c];
        ha_d[c]  = duty[c];
        act_d[c] = 1'b0;
      end else if (sync_strobe ||
                   (!sleep &&
                    (!act_q[c] ||
                     cnt_q[c] == pa_q[c] - ONE))) begin
        cnt_d[c] = ZERO;
        pa_d[c]  = divisor[c];
        ha_d[c]  = duty[c];
        act_d[c] = divisor[c] >= TWO;
        clk_d[c] = act_d[c] && !sleep &&
                   (ZERO < heff(divisor[c], duty[c]));
      end else if (sleep) begin
        cnt_d[c] = cnt_q[c];
      end else begin
        cnt_d[c] = cnt_q[c] + ONE;
        clk_d[c] = cnt_d[c] < heff(pa_q[c], ha_q[c]);
        pd_d[c]  = cnt_d[c] == pa_q[c] - ONE;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      pa_q  <= '0;
      ha_q  <= '0;
      act_q <= '0;
      clk_q <= '0;
      pd_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      pa_q  <= pa_d;
      ha_q  <= ha_d;
      act_q <= act_d;
      clk_q <= clk_d;
      pd_q  <= pd_d;
    end
  end

  assign clk_out     = clk_q;
  assign period_done = pd_q;

endmodule
